// File: rtl/spi_flash_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_read_arbiter
// Brief    : Round-robin burst-read arbiter sharing one single-byte SPI flash
//            read controller between two requesters.
// Revision : 1.0
// ============================================================================
module spi_flash_read_arbiter #(
    parameter int LEN_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [1:0]       req_i,
    input  logic [23:0]      addr0_i,
    input  logic [23:0]      addr1_i,
    input  logic [LEN_W-1:0] len0_i,
    input  logic [LEN_W-1:0] len1_i,
    output logic [1:0]       gnt_o,
    output logic [7:0]       rd_data_o,
    output logic [1:0]       rd_valid_o,
    output logic [1:0]       done_o,
    output logic             busy_o,
    output logic             flash_chipSel_o,
    output logic             flash_readMem_o,
    output logic [23:0]      flash_address_o,
    input  logic [7:0]       flash_dataOut_i,
    input  logic             flash_ready_i
);

    localparam logic [23:0]      C_ADDR_ONE = 24'd1;
    localparam logic [LEN_W-1:0] C_CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GRANT  = 3'd1,
        S_ISSUE  = 3'd2,
        S_GAP    = 3'd3,
        S_FINISH = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_gnt_q, last_gnt_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [23:0]      cur_addr_q, cur_addr_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic [1:0]       rd_valid_q, rd_valid_d;
    logic [1:0]       done_q, done_d;
    logic             busy_q, busy_d;
    logic             cs_q, cs_d;
    logic [23:0]      faddr_q, faddr_d;

    logic [1:0]       w_owner_oh;
    logic [LEN_W-1:0] w_len;
    logic [23:0]      w_addr;
    logic             w_pick;

    assign w_owner_oh = owner_q ? 2'b10 : 2'b01;
    assign w_len      = owner_q ? len1_i : len0_i;
    assign w_addr     = owner_q ? addr1_i : addr0_i;
    // On a tie the port that did not win last time takes the bus.
    assign w_pick     = (req_i == 2'b11) ? ~last_gnt_q : req_i[1];

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_gnt_d = last_gnt_q;
        gnt_d      = gnt_q;
        cur_addr_d = cur_addr_q;
        cnt_d      = cnt_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 2'b00;
        done_d     = 2'b00;
        cs_d       = 1'b0;
        faddr_d    = faddr_q;
        case (state_q)
            S_IDLE: begin
                if (req_i != 2'b00) begin
                    owner_d    = w_pick;
                    last_gnt_d = w_pick;
                    gnt_d      = w_pick ? 2'b10 : 2'b01;
                    state_d    = S_GRANT;
                end
            end
            S_GRANT: begin
                cur_addr_d = w_addr;
                cnt_d      = w_len;
                if (w_len == '0) begin
                    state_d = S_FINISH;
                    done_d  = w_owner_oh;
                end else begin
                    state_d = S_ISSUE;
                    cs_d    = 1'b1;
                    faddr_d = w_addr;
                end
            end
            S_ISSUE: begin
                cs_d = 1'b1;
                if (flash_ready_i) begin
                    rd_data_d  = flash_dataOut_i;
                    rd_valid_d = w_owner_oh;
                    cur_addr_d = cur_addr_q + C_ADDR_ONE;
                    cnt_d      = cnt_q - C_CNT_ONE;
                    cs_d       = 1'b0;
                    if (cnt_q == C_CNT_ONE) begin
                        state_d = S_FINISH;
                        done_d  = w_owner_oh;
                    end else begin
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                state_d = S_ISSUE;
                cs_d    = 1'b1;
                faddr_d = cur_addr_q;
            end
            S_FINISH: begin
                state_d = S_IDLE;
                gnt_d   = 2'b00;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = 2'b00;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b0;
            last_gnt_q <= 1'b1;
            gnt_q      <= 2'b00;
            cur_addr_q <= 24'd0;
            cnt_q      <= '0;
            rd_data_q  <= 8'd0;
            rd_valid_q <= 2'b00;
            done_q     <= 2'b00;
            busy_q     <= 1'b0;
            cs_q       <= 1'b0;
            faddr_q    <= 24'd0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_gnt_q <= last_gnt_d;
            gnt_q      <= gnt_d;
            cur_addr_q <= cur_addr_d;
            cnt_q      <= cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            cs_q       <= cs_d;
            faddr_q    <= faddr_d;
        end
    end

    assign gnt_o           = gnt_q;
    assign rd_data_o       = rd_data_q;
    assign rd_valid_o      = rd_valid_q;
    assign done_o          = done_q;
    assign busy_o          = busy_q;
    assign flash_chipSel_o = cs_q;
    assign flash_readMem_o = cs_q;
    assign flash_address_o = faddr_q;

endmodule
`default_nettype wire
